// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the counter time-sharing scheduler.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_e;

    localparam int MAX_COUNT_DEF = 15;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int width_for(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Requester handshake plus counter hookup seen by the scheduler.
interface counter_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] start_val;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   err;
    logic                   busy;
    logic                   enable;
    logic                   preload;
    logic [CNT_W-1:0]       preload_val;
    logic                   detect;
    logic [CNT_W-1:0]       result;

    modport slave (
        input  req, start_val, detect, result,
        output gnt, done, err, busy, enable, preload, preload_val
    );

    modport master (
        output req, start_val, detect, result,
        input  gnt, done, err, busy, enable, preload, preload_val
    );
endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = width_for(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int j;
        j      = 0;
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr) + i) % N_REQ;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                winner[j] = 1'b1;
                idx       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler time-sharing one preloadable up-counter among requesters.
//   state | meaning
//   IDLE  | no grant; arbitrate among pending requests
//   LOAD  | grant shown, counter preloaded with the winner's start value
//   RUN   | counter enabled until detect, request drop or timeout
//   DONE  | one-cycle completion pulse to the granted requester
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 4,
    parameter int MAX_COUNT = MAX_COUNT_DEF,
    parameter int TIMEOUT   = 2**CNT_W + 2
) (
    input logic            clk,
    input logic            rstn,
    counter_sched_if.slave bus
);

    localparam int               IDX_W    = width_for(N_REQ);
    localparam int               TMR_W    = width_for(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_COUNT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    sched_state_e     state, state_nx;
    logic [IDX_W-1:0] ptr, ptr_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [N_REQ-1:0] sel, sel_nx;
    logic [CNT_W-1:0] pval, pval_nx;
    logic [TMR_W-1:0] run_cnt, run_cnt_nx;
    logic             busy_q;

    logic [N_REQ-1:0] arb_winner;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [CNT_W-1:0] start_sel;
    logic [IDX_W-1:0] ptr_inc;

    logic [N_REQ-1:0] gnt_c, done_c;
    logic             err_c, enable_c, preload_c;

    function automatic logic [CNT_W-1:0] clamp_start(input logic [CNT_W-1:0] v);
        if (int'(v) > MAX_COUNT) return MAX_VAL;
        return v;
    endfunction

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (arb_winner),
        .idx    (arb_idx),
        .valid  (arb_valid)
    );

    always_comb begin
        start_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == arb_idx) start_sel = bus.start_val[i*CNT_W +: CNT_W];
        end
    end

    assign ptr_inc = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            ptr     <= '0;
            idx     <= '0;
            sel     <= '0;
            pval    <= '0;
            run_cnt <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            idx     <= idx_nx;
            sel     <= sel_nx;
            pval    <= pval_nx;
            run_cnt <= run_cnt_nx;
            busy_q  <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        idx_nx     = idx;
        sel_nx     = sel;
        pval_nx    = pval;
        run_cnt_nx = run_cnt;
        gnt_c      = '0;
        done_c     = '0;
        err_c      = 1'b0;
        enable_c   = 1'b0;
        preload_c  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    idx_nx   = arb_idx;
                    sel_nx   = arb_winner;
                    pval_nx  = clamp_start(start_sel);
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                gnt_c      = sel;
                preload_c  = 1'b1;
                run_cnt_nx = '0;
                state_nx   = RUN;
            end
            RUN: begin
                gnt_c = sel;
                // Gating enable with detect keeps the counter parked at MAX_COUNT.
                enable_c = !bus.detect;
                if (bus.detect) begin
                    state_nx = DONE;
                end else if ((bus.req & sel) == '0) begin
                    state_nx = IDLE;
                    ptr_nx   = ptr_inc;
                end else if (run_cnt == TMR_LAST) begin
                    err_c    = 1'b1;
                    state_nx = IDLE;
                    ptr_nx   = ptr_inc;
                end else begin
                    run_cnt_nx = run_cnt + 1'b1;
                end
            end
            DONE: begin
                gnt_c    = sel;
                done_c   = sel;
                ptr_nx   = ptr_inc;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.gnt         = gnt_c;
    assign bus.done        = done_c;
    assign bus.err         = err_c;
    assign bus.busy        = busy_q;
    assign bus.enable      = enable_c;
    assign bus.preload     = preload_c;
    assign bus.preload_val = pval;

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched with a behavioural counter and grant-order model.
module tb_counter_sched;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int MAXC = 15;
    localparam int TO   = 18;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    counter_sched_if #(.N_REQ(N), .CNT_W(W)) bus ();

    counter_sched #(
        .N_REQ     (N),
        .CNT_W     (W),
        .MAX_COUNT (MAXC),
        .TIMEOUT   (TO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Counter under shared use: preload wins over enable, detect at terminal count.
    logic [W-1:0] cnt;
    logic         no_detect;
    always @(posedge clk) begin
        if (!rstn)            cnt <= '0;
        else if (bus.preload) cnt <= bus.preload_val;
        else if (bus.enable)  cnt <= cnt + 1'b1;
    end
    assign bus.result = cnt;
    assign bus.detect = !no_detect && (cnt == W'(MAXC));

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_start(input int i, input int v);
        bus.start_val[i*W +: W] = W'(v);
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // One full grant from the IDLE cycle that sees the request to the IDLE after DONE.
    task automatic do_grant(input int w, input logic [N-1:0] drop);
        int s;
        logic [N-1:0] oh;
        s  = int'(bus.start_val[w*W +: W]);
        if (s > MAXC) s = MAXC;
        oh = N'(1) << w;
        tick();
        check("load_gnt", bus.gnt, oh);
        check("load_preload", bus.preload, 1);
        check("load_pval", bus.preload_val, s);
        check("load_busy", bus.busy, 1);
        check("load_enable", bus.enable, 0);
        for (int k = 0; k <= MAXC - s; k++) begin
            tick();
            check("run_result", bus.result, s + k);
            check("run_gnt", bus.gnt, oh);
            check("run_enable", bus.enable, (s + k != MAXC));
            check("run_done", bus.done, 0);
        end
        tick();
        check("done_pulse", bus.done, oh);
        check("done_gnt", bus.gnt, oh);
        check("done_enable", bus.enable, 0);
        bus.req = bus.req & ~drop;
        ptr_m = (w + 1) % N;
        tick();
        check("idle_gnt", bus.gnt, 0);
        check("idle_done", bus.done, 0);
        check("idle_busy", bus.busy, 0);
    endtask

    initial begin
        logic [N-1:0] mask;
        logic [N-1:0] oh;
        int w;
        bus.req       = '0;
        bus.start_val = '0;
        no_detect     = 1'b0;

        // reset state
        rstn = 1'b0;
        repeat (3) tick();
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_enable", bus.enable, 0);
        check("rst_preload", bus.preload, 0);
        check("rst_pval", bus.preload_val, 0);
        rstn = 1'b1;
        tick();
        ptr_m = 0;

        // single request
        set_start(0, 12);
        bus.req = 4'b0001;
        do_grant(pick(bus.req, ptr_m), 4'b0001);

        // contention from pointer 0
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < N; i++) set_start(i, 14);
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = pick(bus.req, ptr_m);
            check("cont_order", w, g % N);
            do_grant(w, (g == 4) ? 4'b1111 : 4'b0000);
        end

        // start at terminal count
        set_start(2, 15);
        bus.req = 4'b0100;
        do_grant(pick(bus.req, ptr_m), 4'b0100);

        // abort on the second RUN cycle, requester 2 waiting
        set_start(1, 5);
        set_start(2, 13);
        bus.req = 4'b0110;
        w  = pick(bus.req, ptr_m);
        oh = N'(1) << w;
        tick();
        check("abort_load_gnt", bus.gnt, oh);
        tick();
        check("abort_run1_result", bus.result, 5);
        tick();
        check("abort_run2_result", bus.result, 6);
        check("abort_run2_done", bus.done, 0);
        bus.req[w] = 1'b0;
        ptr_m = (w + 1) % N;
        tick();
        check("abort_idle_gnt", bus.gnt, 0);
        check("abort_idle_busy", bus.busy, 0);
        check("abort_idle_done", bus.done, 0);
        do_grant(pick(bus.req, ptr_m), 4'b0100);

        // timeout with detect suppressed
        no_detect = 1'b1;
        set_start(0, 0);
        bus.req = 4'b0001;
        w  = pick(bus.req, ptr_m);
        oh = N'(1) << w;
        tick();
        check("to_load_gnt", bus.gnt, oh);
        for (int k = 0; k < TO; k++) begin
            tick();
            check("to_err", bus.err, (k == TO - 1));
            check("to_gnt", bus.gnt, oh);
            check("to_done", bus.done, 0);
        end
        tick();
        check("to_after_gnt", bus.gnt, 0);
        check("to_after_busy", bus.busy, 0);
        check("to_after_err", bus.err, 0);
        ptr_m = (w + 1) % N;
        bus.req   = '0;
        no_detect = 1'b0;
        tick();

        // reset while the counter sits at 9
        set_start(1, 3);
        bus.req = 4'b0010;
        w = pick(bus.req, ptr_m);
        tick();
        for (int k = 0; k < 7; k++) tick();
        check("mid_result", bus.result, 9);
        rstn = 1'b0;
        tick();
        check("mid_gnt", bus.gnt, 0);
        check("mid_done", bus.done, 0);
        check("mid_err", bus.err, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_enable", bus.enable, 0);
        check("mid_preload", bus.preload, 0);
        check("mid_pval", bus.preload_val, 0);
        rstn    = 1'b1;
        bus.req = '0;
        ptr_m   = 0;
        set_start(3, 7);
        bus.req = 4'b1000;
        do_grant(pick(bus.req, ptr_m), 4'b1000);

        // pointer after reset must start from 0
        rstn = 1'b0;
        tick();
        rstn  = 1'b1;
        ptr_m = 0;
        set_start(1, 13);
        set_start(3, 13);
        bus.req = 4'b1010;
        while (bus.req != '0) begin
            w = pick(bus.req, ptr_m);
            do_grant(w, N'(1) << w);
        end

        // randomized request sets checked against the round-robin model
        for (int r = 0; r < 20; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) set_start(i, $urandom_range(0, MAXC));
            bus.req = mask;
            while (mask != '0) begin
                w = pick(mask, ptr_m);
                do_grant(w, N'(1) << w);
                mask[w] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
